// File: rtl/nano_spi_prog_loader.sv
// SPI mode-0 slave for loading and reading back NanoSys program memory.
// Frame: command byte (0x02 write / 0x03 read), address byte, then data
// bytes with auto-incrementing address. The CPU is held while cs_n is low.
module nano_spi_prog_loader #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_hold,
    output logic              frame_err
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_WR, DATA_RD, IGNORE} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
    logic       sclk_s, cs_s, mosi_s, sclk_q, armed, active, rise, fall;
    logic [7:0] shreg, rd_buf;
    logic [2:0] bit_cnt;
    logic       byte_done, wr_mode, cap_pend;
    logic       enter_cmd, load_addr, do_write, start_pf, set_err, cmd_wr, cmd_rd;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    // Bit activity only counts inside a live frame.
    assign active = !cs_s && (state != IDLE);
    assign rise   = active && sclk_s && !sclk_q;
    assign fall   = active && !sclk_s && sclk_q;

    // Pin synchronizers; 'armed' requires cs_n seen high after the chain has
    // flushed, so a frame cut by rst stays dead until a fresh cs_n fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            flush     <= '0;
            sclk_q    <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
            sclk_q    <= sclk_s;
            if (enter_cmd)
                armed <= 1'b0;
            else if (flush[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    // Bit counter and shift register; rises shift mosi in (except in read
    // data phase), falls in read data phase drive miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (enter_cmd) begin
                bit_cnt <= '0;
            end else if (rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    byte_done <= 1'b1;
                if (state != DATA_RD)
                    shreg <= {shreg[6:0], mosi_s};
            end else if (fall && state == DATA_RD) begin
                if (bit_cnt == 3'd0) begin
                    shreg    <= rd_buf;
                    spi_miso <= rd_buf[7];
                end else begin
                    shreg    <= {shreg[6:0], 1'b0};
                    spi_miso <= shreg[6];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and per-byte actions; cs_n high aborts any frame.
    always_comb begin
        state_nx  = state;
        enter_cmd = 1'b0;
        load_addr = 1'b0;
        do_write  = 1'b0;
        start_pf  = 1'b0;
        set_err   = 1'b0;
        cmd_wr    = 1'b0;
        cmd_rd    = 1'b0;
        if (state != IDLE && cs_s) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (armed && !cs_s) begin
                    state_nx  = CMD;
                    enter_cmd = 1'b1;
                end
                CMD: if (byte_done) begin
                    if (shreg == 8'h02) begin
                        cmd_wr   = 1'b1;
                        state_nx = ADDR;
                    end else if (shreg == 8'h03) begin
                        cmd_rd   = 1'b1;
                        state_nx = ADDR;
                    end else begin
                        set_err  = 1'b1;
                        state_nx = IGNORE;
                    end
                end
                ADDR: if (byte_done) begin
                    load_addr = 1'b1;
                    if (wr_mode) begin
                        state_nx = DATA_WR;
                    end else begin
                        state_nx = DATA_RD;
                        start_pf = 1'b1;
                    end
                end
                DATA_WR: if (byte_done) do_write = 1'b1;
                DATA_RD: if (byte_done) start_pf = 1'b1;
                default: state_nx = state;
            endcase
        end
    end

    // Memory port, prefetch buffer and status outputs. Address increments
    // after each write strobe and on each read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            cap_pend    <= 1'b0;
            rd_buf      <= '0;
            wr_mode     <= 1'b0;
            frame_err   <= 1'b0;
            cpu_hold    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            mem_we      <= do_write;
            mem_re      <= start_pf;
            cap_pend    <= mem_re;
            cpu_hold    <= !cs_s;
            spi_miso_oe <= (state_nx == DATA_RD);
            if (do_write)
                mem_wdata <= shreg;
            if (load_addr)
                mem_addr <= shreg[ADDR_W-1:0];
            else if (mem_we || cap_pend)
                mem_addr <= mem_addr + 1'b1;
            if (cap_pend)
                rd_buf <= mem_rdata;
            if (cmd_wr)
                wr_mode <= 1'b1;
            else if (cmd_rd)
                wr_mode <= 1'b0;
            if (enter_cmd)
                frame_err <= 1'b0;
            else if (set_err)
                frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nano_spi_prog_loader.sv
// Bench for nano_spi_prog_loader: a host drives SPI frames, expected memory
// strobes go into queues, and a monitor pops and compares each strobe.
module tb_nano_spi_prog_loader;

    localparam int CLK  = 10;
    localparam int HALF = 6 * CLK;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re, cpu_hold, frame_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] mem [0:255];
    int         checks = 0;
    int         errors = 0;

    always #(CLK/2) clk = ~clk;

    nano_spi_prog_loader #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .frame_err(frame_err)
    );

    // Program memory model: synchronous write, registered read data.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: every write/read strobe must match the next queued one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we && mem_re) chk("we_re_exclusive", 1, 0);
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write_addr", {24'd0, mem_addr}, 32'h100);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("write_addr", {24'd0, mem_addr}, {24'd0, e.a});
                        chk("write_data", {24'd0, mem_wdata}, {24'd0, e.d});
                    end
                end
                if (mem_re) begin
                    if (exp_rd.size() == 0) begin
                        chk("unexpected_read_addr", {24'd0, mem_addr}, 32'h100);
                    end else begin
                        logic [7:0] ea;
                        ea = exp_rd.pop_front();
                        chk("read_addr", {24'd0, mem_addr}, {24'd0, ea});
                    end
                end
            end
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #(HALF);
            spi_sclk = 1'b1;
            rx[i] = spi_miso;
            #(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        spi_cs_n = 1'b1;
        #(10 * CLK);
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic [7:0] rx;
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(a, rx);
        spi_byte(d0, rx);
        if (n > 1) spi_byte(d1, rx);
        cs_high();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"},      {31'd0, spi_miso},    0);
        chk({tag, "_miso_oe"},   {31'd0, spi_miso_oe}, 0);
        chk({tag, "_mem_addr"},  {24'd0, mem_addr},    0);
        chk({tag, "_mem_wdata"}, {24'd0, mem_wdata},   0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},      0);
        chk({tag, "_mem_re"},    {31'd0, mem_re},      0);
        chk({tag, "_cpu_hold"},  {31'd0, cpu_hold},    0);
        chk({tag, "_frame_err"}, {31'd0, frame_err},   0);
    endtask

    initial begin
        logic [7:0] rx;
        rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;
        #(10 * CLK);

        // Write burst with cpu_hold latency of SYNC_STAGES+1 clocks.
        exp_wr.push_back('{8'h10, 8'hA5});
        exp_wr.push_back('{8'h11, 8'h3C});
        spi_cs_n = 1'b0;
        #(2 * CLK);
        chk("hold_latency_early", {31'd0, cpu_hold}, 0);
        #(CLK);
        chk("hold_latency_on", {31'd0, cpu_hold}, 1);
        #(3 * CLK);
        spi_byte(8'h02, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'hA5, rx);
        chk("wr_oe_low", {31'd0, spi_miso_oe}, 0);
        spi_byte(8'h3C, rx);
        chk("wr_hold_in_frame", {31'd0, cpu_hold}, 1);
        cs_high();
        chk("wr_end_addr", {24'd0, mem_addr}, 32'h12);
        chk("wr_hold_after", {31'd0, cpu_hold}, 0);
        chk("wr_frame_err", {31'd0, frame_err}, 0);
        chk("wr_mem10", {24'd0, mem[8'h10]}, 32'hA5);
        chk("wr_mem11", {24'd0, mem[8'h11]}, 32'h3C);

        // Preload then read back with prefetch of 0x20, 0x21, 0x22.
        exp_wr.push_back('{8'h20, 8'h5A});
        exp_wr.push_back('{8'h21, 8'hC3});
        write_frame(8'h20, 8'h5A, 8'hC3, 2);
        exp_rd.push_back(8'h20);
        exp_rd.push_back(8'h21);
        exp_rd.push_back(8'h22);
        cs_low();
        spi_byte(8'h03, rx);
        chk("rd_oe_cmd", {31'd0, spi_miso_oe}, 0);
        spi_byte(8'h20, rx);
        spi_byte(8'h00, rx);
        chk("rd_byte0", {24'd0, rx}, 32'h5A);
        chk("rd_oe_data", {31'd0, spi_miso_oe}, 1);
        spi_byte(8'h00, rx);
        chk("rd_byte1", {24'd0, rx}, 32'hC3);
        cs_high();
        chk("rd_oe_after", {31'd0, spi_miso_oe}, 0);
        chk("rd_err", {31'd0, frame_err}, 0);

        // Address wrap.
        exp_wr.push_back('{8'hFF, 8'h11});
        exp_wr.push_back('{8'h00, 8'h22});
        write_frame(8'hFF, 8'h11, 8'h22, 2);
        chk("wrap_memFF", {24'd0, mem[8'hFF]}, 32'h11);
        chk("wrap_mem00", {24'd0, mem[8'h00]}, 32'h22);

        // Bad command: sticky error, no strobes; cleared at next cs fall.
        cs_low();
        spi_byte(8'h07, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h99, rx);
        cs_high();
        chk("bad_err_set", {31'd0, frame_err}, 1);
        exp_wr.push_back('{8'h00, 8'h01});
        cs_low();
        chk("bad_err_clr", {31'd0, frame_err}, 0);
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h01, rx);
        cs_high();
        chk("bad_next_mem00", {24'd0, mem[8'h00]}, 32'h01);

        // Aborted byte: partial data byte is dropped.
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h40, rx);
        spi_bits(8'hF8, 5, rx);
        cs_high();
        chk("abort_addr", {24'd0, mem_addr}, 32'h40);
        chk("abort_hold", {31'd0, cpu_hold}, 0);
        exp_wr.push_back('{8'h40, 8'h77});
        write_frame(8'h40, 8'h77, 8'h00, 1);
        chk("abort_mem40", {24'd0, mem[8'h40]}, 32'h77);

        // rst mid data byte: frame dead until a new cs_n fall.
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h50, rx);
        spi_bits(8'hCD, 4, rx);
        rst = 1'b1;
        #(3 * CLK);
        check_reset_outputs("midrst");
        rst = 1'b0;
        #(4 * CLK);
        spi_bits(8'h0D, 4, rx);
        spi_byte(8'hEE, rx);
        cs_high();
        exp_wr.push_back('{8'h50, 8'hAB});
        write_frame(8'h50, 8'hAB, 8'h00, 1);
        chk("rst_mem50", {24'd0, mem[8'h50]}, 32'hAB);
        chk("rst_err", {31'd0, frame_err}, 0);

        #(10 * CLK);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nano_spi_prog_loader.md
Name: nano_spi_prog_loader

Overview:
- SPI-mode-0 slave that lets an external host load and read back the NanoSys program memory through tile pins. This is the chip-side responder to the host initiator.
- Sits between the pin wrapper (ui_in/uo_out/uio) and the program-memory port.
- Holds the CPU in halt while a frame is active.
- Frames: command byte, address byte, then streamed data bytes with auto-increment.

Parameters:
- ADDR_W, 8, program-memory address width (≤8; the address byte supplies the low ADDR_W bits, upper bits ignored).
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs_n and mosi (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset (top-level drives it from ~rst_n).
- spi_sclk  in  1  host SPI clock, asynchronous to clk; its period must be ≥ 8 clk periods.
- spi_cs_n  in  1  host chip select, active low.
- spi_mosi  in  1  host-to-chip data, MSB first.
- spi_miso  out  1  chip-to-host data.
- spi_miso_oe  out  1  output enable for miso pin; 1 only in DATA_RD state with cs active.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe; mem_rdata is valid the cycle after.
- mem_rdata  in  8  read data.
- cpu_hold  out  1  1 while synchronized cs_n is low; CPU must stall.
- frame_err  out  1  sticky error flag; cleared at next cs_n falling edge or by rst.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, cpu_hold=0, frame_err=0, state=IDLE, bit counter=0, synchronizers=1 for cs_n/sclk and 0 for mosi.
- Edge detect on synchronized sclk:
  - rise = sample mosi into the shift register, bit count +1.
  - fall = update miso.
- Byte complete = rise with bit count reaching 8; the counter then wraps to 0.
- States and transitions:
  - IDLE: cs_n low → CMD, counter cleared, frame_err cleared.
  - CMD, on byte complete:
    - 0x02 → ADDR (write mode).
    - 0x03 → ADDR (read mode).
    - anything else → IGNORE, frame_err=1.
  - ADDR, on byte complete: mem_addr ← byte[ADDR_W-1:0].
    - Write mode → DATA_WR.
    - Read mode → DATA_RD and prefetch: mem_re pulses the cycle after, rd_buf captures mem_rdata the next cycle, mem_addr increments the cycle after capture.
  - DATA_WR, on byte complete:
    - mem_wdata ← byte and mem_we=1 for exactly one clk.
    - mem_addr increments the cycle after mem_we; wraps 2^ADDR_W-1 → 0.
  - DATA_RD:
    - On fall with bit count 0: shift register ← rd_buf, miso=rd_buf[7].
    - On other falls: shift left, miso=next bit.
    - On byte complete: prefetch next byte as in ADDR (same re/capture/increment timing). mosi is ignored.
  - IGNORE: consumes bits until cs_n rises.
- cs_n rising in any state → IDLE the next cycle.
  - A partial byte is discarded: no mem_we, no address change.
  - spi_miso_oe=0 and cpu_hold=0 in the same cycle.
- rst mid-frame: immediate return to reset values. The frame stays dead until cs_n goes high then low again, because IDLE waits for a new cs_n fall.
- Latency: cs_n fall at pin → cpu_hold=1 after SYNC_STAGES+1 clk. Last sampling sclk rise → mem_we after SYNC_STAGES+2 clk.
- mem_we and mem_re are never asserted together. At most one memory strobe per byte.
- sclk edges while cs_n high are ignored.

Test Plan:
- Write burst: cs low, bytes 02, 10, A5, 3C, cs high → mem_we pulses twice; mem[0x10]=A5, mem[0x11]=3C; mem_addr ends at 0x12; cpu_hold high only during the frame; frame_err=0.
- Read burst: preload mem[0x20]=5A and mem[0x21]=C3; send 03, 20, then 16 dummy clocks → host shifts in 5A then C3; mem_re pulses 3 times (20, 21, 22); spi_miso_oe=1 only during the data bytes.
- Wrap: write frame 02, FF, 11, 22 with ADDR_W=8 → mem[0xFF]=11, mem[0x00]=22.
- Bad command: 07, 00, 99 → frame_err=1; no mem_we or mem_re. Next frame 02,00,01 clears frame_err at cs fall and writes mem[0x00]=01.
- Aborted byte: 02, 40, then 5 bits, cs high → no mem_we; state returns to IDLE. A subsequent frame 02,40,77 writes mem[0x40]=77.
- rst asserted during DATA_WR byte, then new frame 02,50,AB → all outputs reset values during rst; mem[0x50]=AB afterward; no stray write from the interrupted frame.
